// File: rtl/f_pc_seq_pkg.sv
// Shared constants for the fetch-stage PC sequencer: FSM encodings and the
// default boot PC (text-segment base), also used by the testbench.
package f_pc_seq_pkg;

  localparam logic [1:0] FPC_BOOT  = 2'd0;
  localparam logic [1:0] FPC_FETCH = 2'd1;
  localparam logic [1:0] FPC_HOLD  = 2'd2;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  // A PC is only fetchable when word aligned.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/f_pc_seq.sv
// Fetch-stage PC sequencer. Owns the F-stage PC, issues one instruction
// fetch at a time, presents the fetched word to the F/D register, advances
// to npc when the hazard unit releases stall and retargets on flush.
//
// Memory handshake: im_req is the request valid, im_ack the completion.
// While im_req is high im_addr stays stable until the cycle im_ack is seen;
// that cycle completes the transfer. An im_ack with no outstanding request
// (outside FETCH) is ignored. A request already issued cannot be withdrawn,
// so a flush during a fetch is remembered (drop/pend_pc) and applied when
// the stale data arrives.
module f_pc_seq
  import f_pc_seq_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [AW-1:0] npc,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [31:0]   im_rdata,
  output logic [AW-1:0] f_pc,
  output logic [31:0]   f_instr,
  output logic          f_valid,
  output logic          f_adel,
  output logic [1:0]    dbg_state_o
);

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] f_pc_q,    f_pc_d;
  logic [31:0]   f_instr_q, f_instr_d;
  logic          f_valid_q, f_valid_d;
  logic          f_adel_q,  f_adel_d;
  logic          drop_q,    drop_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;

  // PC load request raised by the state decode, applied uniformly below.
  logic          load_en;
  logic [AW-1:0] load_pc;

  // Next-state decode: decide what happens this cycle, then apply any PC load.
  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    f_instr_d = f_instr_q;
    f_valid_d = f_valid_q;
    f_adel_d  = f_adel_q;
    drop_d    = drop_q;
    pend_pc_d = pend_pc_q;
    load_en   = 1'b0;
    load_pc   = f_pc_q;

    case (state_q)
      FPC_BOOT: begin
        // Reloading the reset PC routes a misaligned RESET_PC to HOLD.
        load_en = 1'b1;
        load_pc = flush ? flush_pc : f_pc_q;
      end
      FPC_FETCH: begin
        if (im_ack) begin
          if (flush) begin
            load_en = 1'b1;
            load_pc = flush_pc;
          end else if (drop_q) begin
            load_en = 1'b1;
            load_pc = pend_pc_q;
          end else begin
            f_instr_d = im_rdata;
            f_valid_d = 1'b1;
            state_d   = FPC_HOLD;
          end
        end else if (flush) begin
          // Latest flush target wins until the stale ack arrives.
          drop_d    = 1'b1;
          pend_pc_d = flush_pc;
        end
      end
      FPC_HOLD: begin
        if (flush) begin
          load_en = 1'b1;
          load_pc = flush_pc;
        end else if (!stall) begin
          load_en = 1'b1;
          load_pc = npc;
        end
      end
      default: begin
        state_d = FPC_BOOT;
      end
    endcase

    if (load_en) begin
      f_pc_d = load_pc;
      drop_d = 1'b0;
      if (pc_misaligned(load_pc[1:0])) begin
        // No fetch for a misaligned PC: present a nop flagged f_adel.
        state_d   = FPC_HOLD;
        f_instr_d = 32'h0;
        f_valid_d = 1'b1;
        f_adel_d  = 1'b1;
      end else begin
        state_d   = FPC_FETCH;
        f_valid_d = 1'b0;
        f_adel_d  = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FPC_BOOT;
      f_pc_q    <= RESET_PC;
      f_instr_q <= 32'h0;
      f_valid_q <= 1'b0;
      f_adel_q  <= 1'b0;
      drop_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      f_pc_q    <= f_pc_d;
      f_instr_q <= f_instr_d;
      f_valid_q <= f_valid_d;
      f_adel_q  <= f_adel_d;
      drop_q    <= drop_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // The ack of a dropped fetch ends that request; the retargeted request
  // is raised from the following cycle.
  assign im_req      = (state_q == FPC_FETCH) && !(drop_q && im_ack);
  assign im_addr     = f_pc_q;
  assign f_pc        = f_pc_q;
  assign f_instr     = f_instr_q;
  assign f_valid     = f_valid_q;
  assign f_adel      = f_adel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_f_pc_seq.sv
// Randomized and directed bench for f_pc_seq. A transaction-level model
// tracks which PC the F stage should be fetching and whether the request
// in flight is stale; deliveries are queued and checked by a monitor.
module tb_f_pc_seq;
  import f_pc_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_adel;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  f_pc_seq dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc        (npc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .f_valid    (f_valid),
    .f_adel     (f_adel),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {adel, pc, instr}
  logic [64:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_fetching: a fetch of m_pc is wanted/outstanding.
  // m_stale: the outstanding request was overtaken by a flush to m_pend.
  bit          m_boot     = 1'b1;
  bit          m_fetching = 1'b0;
  bit          m_stale    = 1'b0;
  bit          m_adel     = 1'b0;
  logic [31:0] m_pc       = DEF_RESET_PC;
  logic [31:0] m_pend     = 32'h0;

  task automatic m_load(input logic [31:0] t);
    m_pc    = t;
    m_stale = 1'b0;
    if (t[1:0] != 2'b00) begin
      m_fetching = 1'b0;
      m_adel     = 1'b1;
      exp_q.push_back({1'b1, t, 32'h0});
    end else begin
      m_fetching = 1'b1;
      m_adel     = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs (at a negedge), check the request outputs,
  // advance the model, then wait for the next negedge.
  task automatic cycle(input logic fl, input logic [31:0] fpc, input logic st,
                       input logic [31:0] np, input logic ak, input logic [31:0] rd);
    bit exp_req;
    flush    = fl;
    flush_pc = fpc;
    stall    = st;
    npc      = np;
    im_ack   = ak;
    im_rdata = rd;
    #1;
    exp_req = m_fetching && !(m_stale && ak);
    chk("im_req", im_req, exp_req);
    chk("im_addr", im_addr, m_pc);
    if (m_boot) begin
      m_boot = 1'b0;
      m_load(fl ? fpc : m_pc);
    end else if (m_fetching) begin
      if (ak) begin
        if (fl)           m_load(fpc);
        else if (m_stale) m_load(m_pend);
        else begin
          exp_q.push_back({1'b0, m_pc, rd});
          m_fetching = 1'b0;
        end
      end else if (fl) begin
        m_stale = 1'b1;
        m_pend  = fpc;
      end
    end else begin
      if (fl)       m_load(fpc);
      else if (!st) m_load(np);
    end
    @(negedge clk);
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] rd);
    for (int i = 0; i < lat; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rd);
  endtask

  task automatic advance(input logic [31:0] np);
    cycle(1'b0, 32'h0, 1'b0, np, 1'b0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  bit          mon_on = 1'b0;
  bit          prev_v = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  bit          prev_adel = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (f_valid && (!prev_v || f_pc != prev_pc || f_adel != prev_adel)) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL f_out: unexpected delivery pc=%0h instr=%0h adel=%0b, none required",
                     f_pc, f_instr, f_adel);
          end else begin
            chk("f_out", {f_adel, f_pc, f_instr}, exp_q.pop_front());
          end
        end
        prev_v    = f_valid;
        prev_pc   = f_pc;
        prev_adel = f_adel;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        fl, st, ak;
    logic [31:0] fpc, np, rd;

    repeat (3) @(negedge clk);
    chk("rst_f_pc", f_pc, DEF_RESET_PC);
    chk("rst_f_valid", f_valid, 1'b0);
    chk("rst_f_adel", f_adel, 1'b0);
    chk("rst_f_instr", f_instr, 32'h0);
    chk("rst_im_req", im_req, 1'b0);
    chk("rst_im_addr", im_addr, DEF_RESET_PC);

    reset  = 1'b1;
    mon_on = 1'b1;

    // Sequential fetches 0x3000, 0x3004, then stall in HOLD at 0x3004.
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_one(1, 32'hA000_0000);
    advance(32'h3004);
    fetch_one(1, 32'hA000_0001);
    cycle(1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 32'h4000, 1'b1, 32'hDEAD_0000);
    cycle(1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 32'h0);
    advance(32'h3008);
    // Flush to 0x4180 one cycle after the 0x3008 request; ack two cycles later.
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h4180, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_3008);
    fetch_one(1, 32'hB000_0000);
    // Flush and ack in the same cycle.
    advance(32'h4184);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h4200, 1'b0, 32'h0, 1'b1, 32'hBAD0_4184);
    fetch_one(0, 32'hB000_0001);
    // Two flushes before a delayed ack: only 0x6000 is fetched.
    advance(32'h4204);
    cycle(1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h6000, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_4204);
    fetch_one(1, 32'hC000_0000);
    // Misaligned npc, then a flush that clears f_adel and resumes.
    advance(32'h3002);
    cycle(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h4180, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_one(0, 32'hC000_0001);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rd  = $urandom();
      fl  = ($urandom_range(0, 7) == 0);
      fpc = $urandom() & 32'hFFFF_FFFC;
      np  = m_adel ? ($urandom() & 32'hFFFF_FFFC) : m_pc + 32'd4;
      if ($urandom_range(0, 3) == 0) np = $urandom() & 32'hFFFF_FFFC;
      if (!m_adel && $urandom_range(0, 7) == 0) np = np | 32'(1 + $urandom_range(0, 2));
      if (!m_adel && $urandom_range(0, 7) == 0) fpc = fpc | 32'(1 + $urandom_range(0, 2));
      st  = ($urandom_range(0, 1) == 0);
      ak  = m_fetching ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      cycle(fl, fpc, st, np, ak, rd);
    end

    // Quiet cycles so the last delivery reaches the monitor.
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
